// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store controller: access sizes,
// controller state type and the alignment rule.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } lsu_state_e;

   // Size 11 is reported through the same error path as a misaligned access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
      logic bad;
      bad = 1'b1;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = offset[0];
         SZ_WORD: bad = (offset != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/load_align_ext.sv
// Load data alignment: pick the addressed lane out of a memory word and
// extend the byte/half field to 32 bits (signed or unsigned).
module load_align_ext
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  offset_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted;
   logic        fill_b;
   logic        fill_h;

   always_comb begin
      shifted = rdata_i >> {offset_i, 3'b000};
      fill_b  = ~unsigned_i & shifted[7];
      fill_h  = ~unsigned_i & shifted[15];
      data_o  = shifted;
      case (size_i)
         SZ_BYTE: data_o = {{24{fill_b}}, shifted[7:0]};
         SZ_HALF: data_o = {{16{fill_h}}, shifted[15:0]};
         default: data_o = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_ctrl.sv
// Single-outstanding load/store unit between a CPU request port and a word memory.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
module load_store_ctrl
   import lsu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_data_o,
   output logic        resp_err_o
);

   lsu_state_e  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        we_q, we_d;
   logic        uns_q, uns_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic        err_q, err_d;

   logic [31:0] ext_data;
   logic [3:0]  be;
   logic [31:0] wdata_rep;
   logic        in_access;
   logic        in_resp;

   load_align_ext u_align (
      .rdata_i    (mem_rdata_i),
      .offset_i   (addr_q[1:0]),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .data_o     (ext_data)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         size_q      <= '0;
         we_q        <= 1'b0;
         uns_q       <= 1'b0;
         wdata_q     <= '0;
         resp_data_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         we_q        <= we_d;
         uns_q       <= uns_d;
         wdata_q     <= wdata_d;
         resp_data_q <= resp_data_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      size_d      = size_q;
      we_d        = we_q;
      uns_d       = uns_q;
      wdata_d     = wdata_q;
      resp_data_d = resp_data_q;
      err_d       = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               addr_d      = req_addr_i;
               size_d      = req_size_i;
               we_d        = req_we_i;
               uns_d       = req_unsigned_i;
               wdata_d     = req_wdata_i;
               resp_data_d = '0;
               err_d       = is_misaligned(req_size_i, req_addr_i[1:0]);
               // Bad accesses skip the memory entirely and answer with an error.
               state_d     = err_d ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            if (mem_ack_i) begin
               resp_data_d = we_q ? 32'd0 : ext_data;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (resp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      be        = 4'b1111;
      wdata_rep = wdata_q;
      case (size_q)
         SZ_BYTE: begin
            be        = 4'b0001 << addr_q[1:0];
            wdata_rep = {4{wdata_q[7:0]}};
         end
         SZ_HALF: begin
            be        = 4'b0011 << addr_q[1:0];
            wdata_rep = {2{wdata_q[15:0]}};
         end
         default: begin
            be        = 4'b1111;
            wdata_rep = wdata_q;
         end
      endcase
   end

   assign in_access    = (state_q == ACCESS);
   assign in_resp      = (state_q == RESP);

   assign req_ready_o  = (state_q == IDLE);
   assign mem_req_o    = in_access;
   assign mem_we_o     = in_access & we_q;
   assign mem_addr_o   = in_access ? {addr_q[31:2], 2'b00} : 32'd0;
   assign mem_be_o     = in_access ? be : 4'b0000;
   assign mem_wdata_o  = in_access ? wdata_rep : 32'd0;
   assign resp_valid_o = in_resp;
   assign resp_data_o  = in_resp ? resp_data_q : 32'd0;
   assign resp_err_o   = in_resp & err_q;

endmodule

// File: doc/load_store_ctrl.md
LOAD_STORE_CTRL -- requirements
Module: load_store_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset; the reset is asynchronous and active-high, with ports named clk_i and rst_i.
REQ-002 clk_i  in  1  clock; every flop samples on the rising edge.
REQ-003 rst_i  in  1  asynchronous active-high reset.
REQ-004 req_valid_i  in  1  CPU access request is valid.
REQ-005 req_ready_o  out  1  block accepts the request this cycle.
REQ-006 req_we_i  in  1  1 = store, 0 = load.
REQ-007 req_size_i  in  2  access size: 00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-008 req_unsigned_i  in  1  load result is zero-extended (1) or sign-extended (0).
REQ-009 req_addr_i  in  32  byte address.
REQ-010 req_wdata_i  in  32  store data, right-aligned.
REQ-011 mem_req_o  out  1  memory access strobe.
REQ-012 mem_we_o  out  1  memory write.
REQ-013 mem_addr_o  out  32  word address, with bits [1:0] = 00.
REQ-014 mem_be_o  out  4  byte enables; bit i selects bits [8i+7:8i].
REQ-015 mem_wdata_o  out  32  store data replicated to its lane.
REQ-016 mem_ack_i  in  1  memory completion; variable latency of 1 to N cycles.
REQ-017 mem_rdata_i  in  32  read word, valid when mem_ack_i = 1.
REQ-018 resp_valid_o  out  1  response available.
REQ-019 resp_ready_i  in  1  CPU takes the response.
REQ-020 resp_data_o  out  32  extended load data; 0 for stores and errors.
REQ-021 resp_err_o  out  1  misaligned or illegal-size access.

Function
REQ-022 The block SHALL implement a three-state FSM with states IDLE, ACCESS and RESP.
- REQ-023 req_ready_o SHALL be 1 only in IDLE.
- A request SHALL be accepted when req_valid_i and req_ready_o are both 1 at a rising edge.
- The block SHALL register addr, size, we, unsigned and wdata at acceptance.
REQ-024 On accept, the FSM SHALL go IDLE -> ACCESS.
- The exception: misaligned access (half with addr[0] = 1, word with addr[1:0] != 00) or size = 11 SHALL go IDLE -> RESP with resp_err_o = 1 and no memory strobe.
REQ-025 In ACCESS, mem_req_o SHALL be 1 and all mem_* outputs SHALL be held stable until mem_ack_i = 1.
- ACCESS -> RESP SHALL occur on the edge where mem_ack_i = 1.
- Minimum latency SHALL be accept edge to resp_valid_o high = 2 edges with a 1-cycle ack.
REQ-026 Byte enables SHALL be: byte = 0001 << addr[1:0]; half = 0011 << addr[1:0]; word = 1111.
- mem_wdata_o SHALL be the byte replicated 4x, the half replicated 2x, or the word as-is.
REQ-027 Load extract: the lane SHALL be selected by the registered addr[1:0] and sized field at bit 0.
- Bits above the field SHALL be filled with the field MSB when unsigned = 0, else with 0.
- mem_rdata_i SHALL be captured on the ack edge.
REQ-028 RESP SHALL hold resp_valid_o, resp_data_o and resp_err_o stable until resp_ready_i = 1.
- RESP -> IDLE SHALL occur on that edge.
- A new request SHALL NOT be accepted on the same edge; there is one cycle of IDLE minimum.
REQ-029 mem_ack_i outside ACCESS SHALL be ignored.
REQ-030 Stores SHALL return resp_data_o = 0 and resp_err_o = 0.

Reset
REQ-031 Asserting rst_i SHALL immediately force IDLE, whatever the current state, including mid-ACCESS.
- All outputs SHALL go to 0 except req_ready_o = 1.
- Registered request fields SHALL clear to 0.
REQ-032 An in-flight memory access interrupted by reset SHALL be abandoned; a late mem_ack_i SHALL be ignored per REQ-029.

Structure
REQ-033 Package lsu_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state type and the misalignment check function.
REQ-034 The extract-and-extend logic SHALL be a combinational sub-module load_align_ext (inputs rdata 32, offset 2, size 2, unsigned 1; output data 32).
- It SHALL generalise the 16-to-32 sign-extend path.

Verification
REQ-035 Load byte signed: addr 0x00000103, mem_rdata 0x80FF7F01, ack after 3 cycles -> mem_addr 0x00000100, be 1000, resp_data 0xFFFFFF80, err 0.
REQ-036 Load half unsigned: addr 0x00000202, rdata 0x8001ABCD, 1-cycle ack -> be 1100, resp_data 0x00008001, resp_valid_o high 2 edges after accept.
REQ-037 Store byte: addr 0x00000011, wdata 0x000000A5 -> mem_we 1, be 0010, mem_wdata 0xA5A5A5A5, resp_data 0.
REQ-038 Misaligned word at 0x00000006 -> mem_req_o never asserts, next cycle resp_valid 1 with err 1.
- The response SHALL hold 3 cycles while resp_ready_i = 0.
REQ-039 Reset mid-ACCESS: rst_i pulsed while mem_req_o = 1 -> mem_req_o = 0 at once and req_ready_o = 1.
- A stray mem_ack_i afterwards SHALL produce no resp_valid_o.
